// File: rtl/ibus_prefetch_unit.sv
// Instruction fetch front-end: issues IBus word reads ahead of decode and
// buffers {PC, instruction} pairs in a small FIFO, with redirect flushing.
module ibus_prefetch_unit #(
    parameter int unsigned         P_DEPTH    = 4,
    parameter int unsigned         P_ADDR_W   = 30,
    parameter int unsigned         P_DATA_W   = 32,
    parameter logic [P_ADDR_W+1:0] P_RESET_PC = '0
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst_n,
    output logic [P_ADDR_W-1:0]       o_IBus_Address,
    output logic                      o_IBus_Read,
    input  logic [P_DATA_W-1:0]       i_IBus_ReadData,
    input  logic                      i_IBus_WaitReq,
    input  logic                      i_Redirect,
    input  logic [P_ADDR_W+1:0]       i_RedirectPc,
    output logic                      o_InstValid,
    output logic [P_DATA_W-1:0]       o_Inst,
    output logic [P_ADDR_W+1:0]       o_InstPc,
    input  logic                      i_InstReady,
    output logic [$clog2(P_DEPTH):0]  o_Count
);

    localparam int unsigned PTR_W = $clog2(P_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(P_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_KILL
    } state_t;

    state_t              state_q, state_d;
    logic                read_q;
    logic [P_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [P_ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [P_ADDR_W-1:0] pc_mem_q   [P_DEPTH];
    logic [P_DATA_W-1:0] data_mem_q [P_DEPTH];

    logic                valid;
    logic                done;
    logic                push;
    logic                pop;
    logic [P_ADDR_W-1:0] redir_word;
    logic                unused_redir_lsbs;

    assign redir_word        = i_RedirectPc[P_ADDR_W+1:2];
    assign unused_redir_lsbs = ^i_RedirectPc[1:0];

    always_comb begin
        valid      = (count_q != '0);
        done       = read_q && !i_IBus_WaitReq;
        push       = (state_q == S_REQ) && done && !i_Redirect;
        pop        = valid && i_InstReady && !i_Redirect;
        count_d    = i_Redirect ? '0 : (count_q + CNT_W'(push) - CNT_W'(pop));
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        case (state_q)
            S_IDLE: begin
                if (i_Redirect) begin
                    fetch_pc_d = redir_word;
                    state_d    = S_REQ;
                end else if (count_q < DEPTH_C) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_Redirect) begin
                    // A stalled read must keep its address on the bus, so the
                    // target waits in pend_pc_q until the killed read retires.
                    if (done) begin
                        fetch_pc_d = redir_word;
                    end else begin
                        pend_pc_d = redir_word;
                        state_d   = S_KILL;
                    end
                end else if (done) begin
                    fetch_pc_d = fetch_pc_q + P_ADDR_W'(1);
                    state_d    = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_KILL: begin
                if (i_Redirect) begin
                    pend_pc_d = redir_word;
                end
                if (done) begin
                    fetch_pc_d = i_Redirect ? redir_word : pend_pc_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_IDLE;
            read_q     <= 1'b0;
            fetch_pc_q <= P_RESET_PC[P_ADDR_W+1:2];
            pend_pc_q  <= P_RESET_PC[P_ADDR_W+1:2];
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            read_q     <= (state_d != S_IDLE);
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            count_q    <= count_d;
            if (i_Redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= i_IBus_ReadData;
        end
    end

    assign o_IBus_Address = fetch_pc_q;
    assign o_IBus_Read    = read_q;
    assign o_InstValid    = valid;
    assign o_Inst         = valid ? data_mem_q[rd_ptr_q] : '0;
    assign o_InstPc       = valid ? {pc_mem_q[rd_ptr_q], 2'b00} : '0;
    assign o_Count        = count_q;

endmodule

// File: tb/tb_ibus_prefetch_unit.sv
// Directed bench for ibus_prefetch_unit: streaming, fill, stalled redirect,
// redirect with pop, PC wrap and asynchronous reset.
module tb_ibus_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] addr, addr2;
    logic        rd, rd2;
    logic [31:0] rdata, rdata2;
    logic        wait_req;
    logic        redir;
    logic [31:0] rpc;
    logic        valid, valid2;
    logic [31:0] inst, inst2;
    logic [31:0] ipc, ipc2;
    logic        ready;
    logic [2:0]  cnt, cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Slave returns word address XOR a fixed pattern
    assign rdata  = {2'b00, addr}  ^ 32'hA5A5A5A5;
    assign rdata2 = {2'b00, addr2} ^ 32'hA5A5A5A5;

    ibus_prefetch_unit #(.P_DEPTH(4), .P_ADDR_W(30), .P_DATA_W(32), .P_RESET_PC(32'h0)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .o_IBus_Address(addr), .o_IBus_Read(rd), .i_IBus_ReadData(rdata),
        .i_IBus_WaitReq(wait_req), .i_Redirect(redir), .i_RedirectPc(rpc),
        .o_InstValid(valid), .o_Inst(inst), .o_InstPc(ipc),
        .i_InstReady(ready), .o_Count(cnt)
    );

    ibus_prefetch_unit #(.P_DEPTH(4), .P_ADDR_W(30), .P_DATA_W(32), .P_RESET_PC(32'h100)) dut2 (
        .i_Clk(clk), .i_Rst_n(rst_n),
        .o_IBus_Address(addr2), .o_IBus_Read(rd2), .i_IBus_ReadData(rdata2),
        .i_IBus_WaitReq(wait_req), .i_Redirect(redir), .i_RedirectPc(rpc),
        .o_InstValid(valid2), .o_Inst(inst2), .o_InstPc(ipc2),
        .i_InstReady(ready), .o_Count(cnt2)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] addr;
        logic        rd;
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        wait_req = 1'b0;
        redir    = 1'b0;
        rpc      = 32'h0;
        ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit found;

        //           redir  rpc           rdy   addr          rd    vld   pc            cnt
        vecs[0] = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        3'd0};
        vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        3'd0};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 32'h1,        1'b1, 1'b1, 32'h0,        3'd1};
        vecs[3] = '{1'b0, 32'h0,        1'b1, 32'h2,        1'b1, 1'b1, 32'h4,        3'd1};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 32'h3,        1'b1, 1'b1, 32'h8,        3'd1};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 32'h4,        1'b1, 1'b1, 32'hC,        3'd1};
        vecs[6] = '{1'b1, 32'h1000,     1'b1, 32'h5,        1'b1, 1'b1, 32'h10,       3'd1};
        vecs[7] = '{1'b0, 32'h0,        1'b1, 32'h400,      1'b1, 1'b0, 32'h0,        3'd0};
        vecs[8] = '{1'b0, 32'h0,        1'b1, 32'h401,      1'b1, 1'b1, 32'h1000,     3'd1};

        // Streaming with zero wait states, then redirect latency
        do_reset();
        for (int i = 0; i < 9; i++) begin
            redir = vecs[i].redir;
            rpc   = vecs[i].rpc;
            ready = vecs[i].ready;
            chk($sformatf("v%0d_addr", i), {2'b00, addr}, vecs[i].addr);
            chk($sformatf("v%0d_read", i), {31'b0, rd}, {31'b0, vecs[i].rd});
            chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
            chk($sformatf("v%0d_count", i), {29'b0, cnt}, {29'b0, vecs[i].cnt});
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_pc", i), ipc, vecs[i].pc);
                chk($sformatf("v%0d_inst", i), inst, {2'b00, vecs[i].pc[31:2]} ^ 32'hA5A5A5A5);
            end
            step();
        end
        redir = 1'b0;

        // Fill with decode stalled, then one pop frees exactly one slot
        do_reset();
        ready = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            if (rd && !wait_req) n++;
            step();
        end
        chk("fill_reads", n, 4);
        chk("fill_read_low", {31'b0, rd}, 32'd0);
        chk("fill_count", {29'b0, cnt}, 32'd4);
        chk("fill_head_pc", ipc, 32'h0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("pop_count", {29'b0, cnt}, 32'd3);
        chk("pop_head_pc", ipc, 32'h4);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (rd && !wait_req) n++;
            step();
        end
        chk("refill_reads", n, 1);
        chk("refill_count", {29'b0, cnt}, 32'd4);

        // Redirect during a stalled read at word 0x4
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (rd && addr == 30'h4) found = 1'b1;
            else step();
        end
        chk("stall_reach_addr4", {31'b0, found}, 32'd1);
        wait_req = 1'b1;
        step();
        redir = 1'b1;
        rpc   = 32'h200;
        chk("stall2_addr", {2'b00, addr}, 32'h4);
        step();
        redir = 1'b0;
        chk("stall3_addr", {2'b00, addr}, 32'h4);
        chk("stall3_read", {31'b0, rd}, 32'd1);
        chk("stall3_count", {29'b0, cnt}, 32'd0);
        step();
        wait_req = 1'b0;
        chk("kill_done_addr", {2'b00, addr}, 32'h4);
        chk("kill_done_read", {31'b0, rd}, 32'd1);
        step();
        chk("kill_next_addr", {2'b00, addr}, 32'h80);
        chk("kill_next_valid", {31'b0, valid}, 32'd0);
        chk("kill_next_count", {29'b0, cnt}, 32'd0);
        step();
        chk("kill_head_valid", {31'b0, valid}, 32'd1);
        chk("kill_head_pc", ipc, 32'h200);
        chk("kill_head_inst", inst, 32'h80 ^ 32'hA5A5A5A5);
        chk("kill_head_count", {29'b0, cnt}, 32'd1);

        // Redirect coinciding with a completion and a pop at count 2
        do_reset();
        ready = 1'b0;
        repeat (3) step();
        chk("rp_pre_count", {29'b0, cnt}, 32'd2);
        ready = 1'b1;
        redir = 1'b1;
        rpc   = 32'h300;
        step();
        redir = 1'b0;
        chk("rp_count", {29'b0, cnt}, 32'd0);
        chk("rp_valid", {31'b0, valid}, 32'd0);
        chk("rp_addr", {2'b00, addr}, 32'hC0);
        step();
        chk("rp_head_pc", ipc, 32'h300);
        chk("rp_head_inst", inst, 32'hC0 ^ 32'hA5A5A5A5);

        // Fetch PC wrap at the top of the address space
        redir = 1'b1;
        rpc   = 32'hFFFFFFFC;
        step();
        redir = 1'b0;
        chk("wrap_addr_top", {2'b00, addr}, 32'h3FFFFFFF);
        step();
        chk("wrap_addr_zero", {2'b00, addr}, 32'h0);
        chk("wrap_pc_top", ipc, 32'hFFFFFFFC);
        chk("wrap_inst_top", inst, 32'h3FFFFFFF ^ 32'hA5A5A5A5);
        step();
        chk("wrap_pc_zero", ipc, 32'h0);
        chk("wrap_inst_zero", inst, 32'hA5A5A5A5);

        // Asynchronous reset asserted mid-stall, between edges
        wait_req = 1'b1;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_read", {31'b0, rd}, 32'd0);
        chk("areset_valid", {31'b0, valid}, 32'd0);
        chk("areset_count", {29'b0, cnt}, 32'd0);
        chk("areset_inst", inst, 32'h0);
        chk("areset_pc", ipc, 32'h0);
        chk("areset_read2", {31'b0, rd2}, 32'd0);
        chk("areset_count2", {29'b0, cnt2}, 32'd0);
        wait_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rstpc_idle_addr", {2'b00, addr2}, 32'h40);
        chk("rstpc_idle_read", {31'b0, rd2}, 32'd0);
        step();
        chk("rstpc_first_addr", {2'b00, addr2}, 32'h40);
        chk("rstpc_first_read", {31'b0, rd2}, 32'd1);
        step();
        chk("rstpc_second_addr", {2'b00, addr2}, 32'h41);
        chk("rstpc_head_pc", ipc2, 32'h100);
        chk("rstpc_head_inst", inst2, 32'h40 ^ 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
